// File: rtl/lsu_ctrl_if.sv
// Data-memory port of the load/store unit: req/gnt request phase, rvalid response phase.
// master = LSU side, slave = memory side.
interface lsu_ctrl_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_ctrl.sv
// Execute-stage load/store unit: one outstanding access, watchdog-bounded, aligned/extended loads.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of masking the low bits.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        misalign_o,
  lsu_ctrl_if.master  mem
);
  localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_e;
  state_e state_q, state_d;

  logic           we_q, uns_q, err_q;
  logic [1:0]     size_q, lane_q;
  logic [3:0]     be_q, be_d;
  logic [31:0]    addr_q, wdata_q, wdata_d, rdata_q, load_d;
  logic [WDW-1:0] wdog_q;
  logic           timeout;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_d, mis_q;
  assign misalign_d = ((size_i == 2'b01) && addr_i[0]) ||
                      (size_i[1] && (addr_i[1:0] != 2'b00));
`endif

  // Watchdog fires on the last permitted cycle so the abort lands exactly TIMEOUT cycles in.
  assign timeout = (TIMEOUT != 0) && (wdog_q == WDW'(TIMEOUT - 1));

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata_i;
    case (size_i)
      2'b00: begin
        be_d    = 4'b0001 << addr_i[1:0];
        wdata_d = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_d = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b      = mem.rdata[{lane_q, 3'b000} +: 8];
    h      = lane_q[1] ? mem.rdata[31:16] : mem.rdata[15:0];
    load_d = mem.rdata;
    case (size_q)
      2'b00:   load_d = {{24{~uns_q & b[7]}}, b};
      2'b01:   load_d = {{16{~uns_q & h[15]}}, h};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
`ifdef LSU_MISALIGN_TRAP_EN
          state_d = misalign_d ? ST_RESP : ST_REQ;
`else
          state_d = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        if (mem.gnt)      state_d = we_q ? ST_RESP : ST_WAIT;
        else if (timeout) state_d = ST_RESP;
      end
      ST_WAIT: if (mem.rvalid || timeout) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      wdog_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      lane_q  <= '0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_d != state_q)                           wdog_q <= '0;
      else if (state_q == ST_REQ || state_q == ST_WAIT) wdog_q <= wdog_q + WDW'(1);
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            we_q    <= we_i;
            uns_q   <= unsigned_i;
            size_q  <= size_i;
            lane_q  <= addr_i[1:0];
            addr_q  <= {addr_i[31:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= misalign_d;
            mis_q   <= misalign_d;
`else
            err_q   <= 1'b0;
`endif
          end
        end
        ST_REQ: if (!mem.gnt && timeout) err_q <= 1'b1;
        ST_WAIT: begin
          if (mem.rvalid)   rdata_q <= load_d;
          else if (timeout) err_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready_o   = (state_q == ST_IDLE);
  assign done_o    = (state_q == ST_RESP);
  assign rdata_o   = done_o ? rdata_q : '0;
  assign err_o     = done_o & err_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_o = done_o & mis_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign mem.req   = (state_q == ST_REQ);
  assign mem.we    = we_q;
  assign mem.be    = be_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl (TIMEOUT=4); responses are checked against a scoreboard queue.
// Latencies are counted inclusively: accept cycle through done cycle.
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst, valid, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ready, done, err, mis;
  logic [31:0] rdata;

  lsu_ctrl_if mem ();

  lsu_ctrl #(.TIMEOUT(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .valid_i    (valid),
    .ready_o    (ready),
    .we_i       (we),
    .size_i     (size),
    .unsigned_i (uns),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .done_o     (done),
    .rdata_o    (rdata),
    .err_o      (err),
    .misalign_o (mis),
    .mem        (mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int          cyc = 0;
  int          acc_cyc, done_cyc;
  bit          done_seen;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Every completion must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      chk("sb_depth_at_done", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.tag, "_rdata"},    rdata,      e.rdata);
        chk({e.tag, "_err"},      32'(err),   32'(e.err));
        chk({e.tag, "_misalign"}, 32'(mis),   32'(e.mis));
      end
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    valid = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
    @(posedge clk); #1;
    acc_cyc   = cyc;
    done_seen = 1'b0;
    valid     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int elat);
    int g = 0;
    while (!done_seen && g < 20) begin
      @(negedge clk); #1;
      g++;
    end
    chk({tag, "_done_seen"}, 32'(done_seen), 32'd1);
    if (done_seen) chk({tag, "_latency"}, 32'(done_cyc - acc_cyc + 2), 32'(elat));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done),  32'd0);
    chk({tag, "_ready"},      32'(ready), 32'd1);
  endtask

  task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int gnt_wait, input logic [3:0] ebe, input logic [31:0] eaddr,
                        input logic [31:0] ewd, input logic [31:0] erd, input int elat);
    sb.push_back('{rdata: erd, err: 1'b0, mis: 1'b0, tag: tag});
    issue(w, sz, u, a, wd);
    repeat (gnt_wait) begin
      @(negedge clk);
      chk({tag, "_req_held"}, 32'(mem.req), 32'd1);
      @(posedge clk); #1;
    end
    mem.gnt = 1'b1;
    @(negedge clk);
    chk({tag, "_req"},   32'(mem.req), 32'd1);
    chk({tag, "_we"},    32'(mem.we),  32'(w));
    chk({tag, "_be"},    32'(mem.be),  32'(ebe));
    chk({tag, "_addr"},  mem.addr,     eaddr);
    chk({tag, "_wdata"}, mem.wdata,    ewd);
    @(posedge clk); #1;
    mem.gnt = 1'b0;
    if (!w) begin
      mem.rvalid = 1'b1;
      mem.rdata  = rd;
      @(posedge clk); #1;
      mem.rvalid = 1'b0;
      mem.rdata  = '0;
    end
    wait_done(tag, elat);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int req_cnt;
    int g;
    rst = 1'b1; valid = 1'b0; we = 1'b0; size = '0; uns = 1'b0; addr = '0; wdata = '0;
    mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",    32'(ready),   32'd1);
    chk("rst_done",     32'(done),    32'd0);
    chk("rst_err",      32'(err),     32'd0);
    chk("rst_mis",      32'(mis),     32'd0);
    chk("rst_rdata",    rdata,        32'd0);
    chk("rst_mem_req",  32'(mem.req), 32'd0);
    chk("rst_mem_we",   32'(mem.we),  32'd0);
    chk("rst_mem_be",   32'(mem.be),  32'd0);
    chk("rst_mem_addr", mem.addr,     32'd0);
    chk("rst_mem_wd",   mem.wdata,    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    access("sw",  1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 32'h100, 32'hDEADBEEF, 32'h0, 3);
    access("sb",  1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5, 32'h0, 0, 4'b1000, 32'h100, 32'hA5A5A5A5, 32'h0, 3);
    access("sh",  1'b1, 2'b01, 1'b0, 32'h102, 32'h00001234, 32'h0, 2, 4'b1100, 32'h100, 32'h12341234, 32'h0, 5);
    access("lb",  1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 32'h12F45678, 0, 4'b0100, 32'h100, 32'h0, 32'hFFFFFFF4, 4);
    access("lbu", 1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 32'h12F45678, 0, 4'b0100, 32'h100, 32'h0, 32'h000000F4, 4);
    access("lh",  1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80011234, 0, 4'b1100, 32'h100, 32'h0, 32'hFFFF8001, 4);
    access("lhu", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h80011234, 0, 4'b1100, 32'h100, 32'h0, 32'h00008001, 4);
    access("lw",  1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'h89ABCDEF, 1, 4'b1111, 32'h104, 32'h0, 32'h89ABCDEF, 5);

    // Store with no grant: request held for TIMEOUT cycles, then an error completion.
    sb.push_back('{rdata: 32'h0, err: 1'b1, mis: 1'b0, tag: "tmo"});
    issue(1'b1, 2'b10, 1'b0, 32'h200, 32'h55AA55AA);
    req_cnt = 0;
    g = 0;
    while (!done_seen && g < 20) begin
      @(negedge clk);
      if (mem.req) req_cnt++;
      #1;
      g++;
    end
    chk("tmo_req_cycles", 32'(req_cnt), 32'd4);
    chk("tmo_done_seen",  32'(done_seen), 32'd1);
    chk("tmo_latency",    32'(done_cyc - acc_cyc + 2), 32'd6);
    @(negedge clk);
    chk("tmo_req_after",  32'(mem.req), 32'd0);

`ifdef LSU_MISALIGN_TRAP_EN
    sb.push_back('{rdata: 32'h0, err: 1'b1, mis: 1'b1, tag: "lw_mis"});
    issue(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
    @(negedge clk);
    chk("lw_mis_no_req", 32'(mem.req), 32'd0);
    wait_done("lw_mis", 2);
    chk("lw_mis_no_req_after", 32'(mem.req), 32'd0);
`else
    access("lw_mis", 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'hCAFEF00D, 0, 4'b1111, 32'h100, 32'h0, 32'hCAFEF00D, 4);
`endif

    // Reset while waiting for load data; the late rvalid must be ignored.
    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    mem.gnt = 1'b1;
    @(posedge clk); #1;
    mem.gnt = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem.rvalid = 1'b1;
    mem.rdata  = 32'h11111111;
    @(posedge clk); #1;
    mem.rvalid = 1'b0;
    mem.rdata  = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstw_done",  32'(done),    32'd0);
      chk("rstw_ready", 32'(ready),   32'd1);
      chk("rstw_req",   32'(mem.req), 32'd0);
      chk("rstw_rdata", rdata,        32'd0);
      chk("rstw_err",   32'(err),     32'd0);
    end

    access("sw_after_rst", 1'b1, 2'b10, 1'b0, 32'h404, 32'h01234567, 32'h0, 0, 4'b1111, 32'h404, 32'h01234567, 32'h0, 3);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
